// File: rtl/led_status.sv
// Status LED driver: free-running heartbeat, per-event pulse stretchers and a
// blink-code error display, with off / lamp-test / debug-mirror override modes.
//
// Error FSM states
//   state  | meaning
//   S_IDLE | no error shown; waits for a nonzero err_strobe
//   S_ON   | error LED lit for BLINK cycles
//   S_OFF  | error LED dark for BLINK cycles between blinks
//   S_GAP  | error LED dark for GAP cycles before the code repeats
module led_status #(
   parameter int LED_WIDTH = 8,
   parameter int NUM_EVT   = 3,
   parameter int HB_HALF   = 6000000,
   parameter int STRETCH   = 1200000,
   parameter int BLINK     = 2000000,
   parameter int GAP       = 8000000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [1:0]           mode,
   input  logic [NUM_EVT-1:0]   evt,
   input  logic [LED_WIDTH-1:0] dbg_data,
   input  logic [3:0]           err_code,
   input  logic                 err_strobe,
   input  logic                 err_clear,
   output logic [LED_WIDTH-1:0] led
);

   localparam int HBW    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
   localparam int STW    = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
   localparam int PH_MAX = (BLINK > GAP) ? BLINK : GAP;
   localparam int PHW    = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

   localparam logic [HBW-1:0] HB_LAST  = HBW'(HB_HALF - 1);
   localparam logic [STW-1:0] ST_LOAD  = STW'(STRETCH);
   localparam logic [PHW-1:0] PH_BLINK = PHW'(BLINK);
   localparam logic [PHW-1:0] PH_GAP   = PHW'(GAP);
   localparam logic [PHW-1:0] PH_ONE   = PHW'(1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} err_state_t;

   logic [HBW-1:0] hb_cnt, hb_cnt_n;
   logic           hb, hb_n;
   logic [STW-1:0] st_cnt   [NUM_EVT];
   logic [STW-1:0] st_cnt_n [NUM_EVT];
   logic [NUM_EVT-1:0] chan_n;

   err_state_t     state, state_n;
   logic [PHW-1:0] ph, ph_n;
   logic [3:0]     cur_code, cur_code_n;
   logic [3:0]     blinks_left, blinks_left_n;
   logic [3:0]     pend_code, pend_code_n;
   logic           pend_valid, pend_valid_n;
   logic           err_bit_n;
   logic [LED_WIDTH-1:0] led_n;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hb_cnt      <= '0;
         hb          <= 1'b0;
         for (int i = 0; i < NUM_EVT; i++) st_cnt[i] <= '0;
         state       <= S_IDLE;
         ph          <= '0;
         cur_code    <= '0;
         blinks_left <= '0;
         pend_code   <= '0;
         pend_valid  <= 1'b0;
         led         <= '0;
      end else begin
         hb_cnt      <= hb_cnt_n;
         hb          <= hb_n;
         for (int i = 0; i < NUM_EVT; i++) st_cnt[i] <= st_cnt_n[i];
         state       <= state_n;
         ph          <= ph_n;
         cur_code    <= cur_code_n;
         blinks_left <= blinks_left_n;
         pend_code   <= pend_code_n;
         pend_valid  <= pend_valid_n;
         led         <= led_n;
      end
   end

   always_comb begin
      hb_cnt_n = hb_cnt + 1'b1;
      hb_n     = hb;
      if (hb_cnt == HB_LAST) begin
         hb_cnt_n = '0;
         hb_n     = ~hb;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_EVT; i++) begin
         st_cnt_n[i] = st_cnt[i];
         if (evt[i])
            st_cnt_n[i] = ST_LOAD;
         else if (st_cnt[i] != '0)
            st_cnt_n[i] = st_cnt[i] - 1'b1;
         chan_n[i] = (st_cnt_n[i] != '0);
      end
   end

   always_comb begin
      state_n       = state;
      ph_n          = ph;
      cur_code_n    = cur_code;
      blinks_left_n = blinks_left;
      pend_code_n   = pend_code;
      pend_valid_n  = pend_valid;
      case (state)
         S_IDLE: begin
            if (err_strobe && err_code != 4'd0) begin
               state_n       = S_ON;
               ph_n          = PH_BLINK;
               cur_code_n    = err_code;
               blinks_left_n = err_code;
            end
         end
         S_ON: begin
            if (ph == PH_ONE) begin
               state_n       = S_OFF;
               ph_n          = PH_BLINK;
               blinks_left_n = blinks_left - 1'b1;
            end else begin
               ph_n = ph - 1'b1;
            end
         end
         S_OFF: begin
            if (ph == PH_ONE) begin
               if (blinks_left != 4'd0) begin
                  state_n = S_ON;
                  ph_n    = PH_BLINK;
               end else begin
                  state_n = S_GAP;
                  ph_n    = PH_GAP;
               end
            end else begin
               ph_n = ph - 1'b1;
            end
         end
         S_GAP: begin
            if (ph == PH_ONE) begin
               state_n = S_ON;
               ph_n    = PH_BLINK;
               if (pend_valid) begin
                  cur_code_n    = pend_code;
                  blinks_left_n = pend_code;
                  pend_valid_n  = 1'b0;
               end else begin
                  blinks_left_n = cur_code;
               end
            end else begin
               ph_n = ph - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // A strobe landing on the repeat boundary is queued for the following repeat.
      if (state != S_IDLE && err_strobe && err_code != 4'd0) begin
         pend_code_n  = err_code;
         pend_valid_n = 1'b1;
      end
      if (err_clear) begin
         state_n       = S_IDLE;
         ph_n          = '0;
         cur_code_n    = '0;
         blinks_left_n = '0;
         pend_code_n   = '0;
         pend_valid_n  = 1'b0;
      end
      err_bit_n = (state_n == S_ON);
   end

   // led is built from next-state values so it lines up with the state registers.
   always_comb begin
      led_n = '0;
      case (mode)
         2'd0: begin
            led_n[0] = hb_n;
            for (int i = 0; i < NUM_EVT; i++) led_n[1+i] = chan_n[i];
            led_n[LED_WIDTH-1] = err_bit_n;
         end
         2'd1: led_n = '0;
         2'd2: led_n = '1;
         default: led_n = dbg_data;
      endcase
   end

endmodule
